// File: rtl/count_wrap_tracker.sv
// count_wrap_tracker: follows a small up/down counter, extends it with a wrap
// count, and latches a fault when a counter step does not match its inputs.
module count_wrap_tracker #(
    parameter int unsigned CNT_W = 3,
    parameter int unsigned EXT_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CNT_W-1:0]       cnt_q,
    input  logic                   cnt_dir,
    input  logic                   cnt_clr,
    input  logic                   err_clr,
    output logic [CNT_W+EXT_W-1:0] ext_q,
    output logic                   trk_valid,
    output logic                   wrap_up,
    output logic                   wrap_dn,
    output logic                   ovf,
    output logic                   err
);

    localparam int unsigned POS_W = CNT_W + EXT_W;

    localparam logic [1:0] S_SYNC  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] prev_q;
    logic             prev_dir;
    logic             prev_clr;

    logic [EXT_W-1:0] upper;
    logic [EXT_W-1:0] upper_nxt;
    logic [CNT_W-1:0] exp_q;
    logic [POS_W-1:0] ext_nxt;
    logic             trk_nxt;
    logic             wrap_up_nxt;
    logic             wrap_dn_nxt;
    logic             ovf_nxt;
    logic             err_nxt;

    // The upper field lives in the top bits of the registered position.
    assign upper = ext_q[POS_W-1:CNT_W];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Remember what the counter showed and was told to do last cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q   <= '0;
            prev_dir <= 1'b0;
            prev_clr <= 1'b0;
        end else begin
            prev_q   <= cnt_q;
            prev_dir <= cnt_dir;
            prev_clr <= cnt_clr;
        end
    end

    // Value the counter must show now, given last cycle's value and controls.
    always_comb begin
        exp_q = prev_q - CNT_W'(1);
        if (prev_clr) begin
            exp_q = '0;
        end else if (prev_dir) begin
            exp_q = prev_q + CNT_W'(1);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        upper_nxt   = upper;
        ext_nxt     = ext_q;
        wrap_up_nxt = 1'b0;
        wrap_dn_nxt = 1'b0;
        ovf_nxt     = ovf;
        err_nxt     = err;

        case (state)
            S_SYNC: begin
                upper_nxt = '0;
                ext_nxt   = {EXT_W'(0), cnt_q};
                state_nxt = S_TRACK;
            end
            S_TRACK: begin
                if (cnt_q != exp_q) begin
                    // Position and wrap count freeze at the last good value.
                    err_nxt   = 1'b1;
                    if (err_clr) begin
                        ovf_nxt = 1'b0;
                    end
                    state_nxt = S_FAULT;
                end else begin
                    if (err_clr) begin
                        ovf_nxt = 1'b0;
                        err_nxt = 1'b0;
                    end
                    if (prev_clr) begin
                        upper_nxt = '0;
                    end else if (prev_dir && (prev_q == '1)) begin
                        upper_nxt   = upper + EXT_W'(1);
                        wrap_up_nxt = 1'b1;
                        if (upper == '1) begin
                            ovf_nxt = 1'b1;
                        end
                    end else if (!prev_dir && (prev_q == '0)) begin
                        upper_nxt   = upper - EXT_W'(1);
                        wrap_dn_nxt = 1'b1;
                        if (upper == '0) begin
                            ovf_nxt = 1'b1;
                        end
                    end
                    ext_nxt = {upper_nxt, cnt_q};
                end
            end
            S_FAULT: begin
                if (err_clr) begin
                    err_nxt   = 1'b0;
                    ovf_nxt   = 1'b0;
                    state_nxt = S_SYNC;
                end
            end
            default: begin
                state_nxt = S_SYNC;
            end
        endcase

        trk_nxt = (state_nxt == S_TRACK);
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_q     <= '0;
            trk_valid <= 1'b0;
            wrap_up   <= 1'b0;
            wrap_dn   <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            ext_q     <= ext_nxt;
            trk_valid <= trk_nxt;
            wrap_up   <= wrap_up_nxt;
            wrap_dn   <= wrap_dn_nxt;
            ovf       <= ovf_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_count_wrap_tracker.sv
// Scoreboard bench for count_wrap_tracker: an upstream counter model drives
// cnt_q, a position-level reference predicts each registered output.
module tb_count_wrap_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] cnt_q;
    logic       cnt_dir;
    logic       cnt_clr;
    logic       err_clr;
    logic [7:0] ext_q;
    logic       trk_valid;
    logic       wrap_up;
    logic       wrap_dn;
    logic       ovf;
    logic       err;

    count_wrap_tracker #(.CNT_W(3), .EXT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_q     (cnt_q),
        .cnt_dir   (cnt_dir),
        .cnt_clr   (cnt_clr),
        .err_clr   (err_clr),
        .ext_q     (ext_q),
        .trk_valid (trk_valid),
        .wrap_up   (wrap_up),
        .wrap_dn   (wrap_dn),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] ext;
        logic       valid;
        logic       wu;
        logic       wd;
        logic       ovf;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: mode 0 = resyncing, 1 = tracking, 2 = faulted.
    int   m_mode = 0;
    int   m_ext  = 0;
    bit   m_ovf  = 1'b0;
    bit   m_err  = 1'b0;
    int   m_pq   = 0;
    bit   m_pd   = 1'b0;
    bit   m_pc   = 1'b0;
    int   cnt    = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every cycle compare the DUT against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("ext_q",     int'(ext_q),     int'(e.ext));
                check("trk_valid", int'(trk_valid), int'(e.valid));
                check("wrap_up",   int'(wrap_up),   int'(e.wu));
                check("wrap_dn",   int'(wrap_dn),   int'(e.wd));
                check("ovf",       int'(ovf),       int'(e.ovf));
                check("err",       int'(err),       int'(e.err));
            end
        end
    end

    // One clock of stimulus; the prediction for the coming edge is queued.
    task automatic step(input bit r, input bit dir, input bit clr, input bit eclr, input bit inject);
        int   q;
        int   expq;
        bit   wu;
        bit   wd;
        bit   set;
        exp_t e;
        @(negedge clk);
        #1;
        q = inject ? (cnt + int'($urandom_range(1, 7))) % 8 : cnt;
        rst     = r;
        cnt_q   = 3'(q);
        cnt_dir = dir;
        cnt_clr = clr;
        err_clr = eclr;
        wu = 1'b0;
        wd = 1'b0;
        if (!r) begin
            m_mode = 0; m_ext = 0; m_ovf = 1'b0; m_err = 1'b0;
            m_pq = 0; m_pd = 1'b0; m_pc = 1'b0;
        end else begin
            expq = m_pc ? 0 : (m_pd ? (m_pq + 1) % 8 : (m_pq + 7) % 8);
            case (m_mode)
                0: begin
                    m_ext  = q;
                    m_mode = 1;
                end
                1: begin
                    if (q != expq) begin
                        m_err  = 1'b1;
                        if (eclr) m_ovf = 1'b0;
                        m_mode = 2;
                    end else begin
                        set = 1'b0;
                        if (m_pc) begin
                            m_ext = 0;
                        end else if (m_pd) begin
                            set   = (m_ext == 255);
                            wu    = (m_pq == 7);
                            m_ext = (m_ext + 1) % 256;
                        end else begin
                            set   = (m_ext == 0);
                            wd    = (m_pq == 0);
                            m_ext = (m_ext + 255) % 256;
                        end
                        m_ovf = set | (m_ovf & !eclr);
                        if (eclr) m_err = 1'b0;
                    end
                end
                default: begin
                    if (eclr) begin
                        m_err  = 1'b0;
                        m_ovf  = 1'b0;
                        m_mode = 0;
                    end
                end
            endcase
            m_pq = q; m_pd = dir; m_pc = clr;
        end
        e.ext   = 8'(m_ext);
        e.valid = (m_mode == 1);
        e.wu    = wu;
        e.wd    = wd;
        e.ovf   = m_ovf;
        e.err   = m_err;
        sb.push_back(e);
        if (!r) begin
            // Reset acts without a clock edge.
            #1;
            check("async_rst_ext", int'(ext_q), 0);
            check("async_rst_flags", int'({trk_valid, wrap_up, wrap_dn, ovf, err}), 0);
        end
        cnt = !r ? 0 : (clr ? 0 : (dir ? (cnt + 1) % 8 : (cnt + 7) % 8));
    endtask

    initial begin
        rst = 1'b0; cnt_q = '0; cnt_dir = 1'b0; cnt_clr = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Free-running up count through two up-wraps.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Count down across wraps, through 0 with upper at 0.
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        // Up by 270 rolls the upper field from all-ones back to 0.
        for (int i = 0; i < 270; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Clear mid-count, then a clear followed by a bad value.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Injected step error, held fault, then recovery.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Reset mid-count.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 127) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 31) == 0));
        end
        repeat (3) @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
